// File: rtl/addr_encoder_sync.sv
// rtl/addr_encoder_sync.sv - synchronised, debounced one-hot selector to binary address encoder
module addr_encoder_sync #(
    parameter int N          = 15,
    parameter int AW         = 4,
    parameter int DEB_CYCLES = 4,
    parameter int PRIORITY   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  addr_in,
    output logic [AW-1:0] addr_out,
    output logic          addr_valid,
    output logic          key_held,
    output logic          err,
    output logic          key_release
);
    typedef enum logic [1:0] {IDLE, DEB, HELD, LOCK} state_t;

    localparam int            CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [N-1:0]  BUS_ONE  = N'(1);

    logic [N-1:0]  sync1, sync2, cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx;
    state_t        state, state_nx;
    logic [AW-1:0] addr_nx, cand_addr;
    logic          valid_nx, err_nx, rel_nx, onehot;

    // Ascending scan: the last set bit seen is the highest, which gives bit N-1 top priority.
    always_comb begin
        cand_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) cand_addr = (i == N - 1) ? '0 : AW'(i + 1);
        end
    end

    assign onehot = ((cand & (cand - BUS_ONE)) == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        addr_nx  = addr_out;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        rel_nx   = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync2 != '0) begin
                        cand_nx  = sync2;
                        cnt_nx   = CNT_ONE;
                        state_nx = DEB;
                    end
                end
                DEB: begin
                    if (sync2 == '0) begin
                        state_nx = IDLE;
                    end else if (sync2 != cand) begin
                        cand_nx = sync2;
                        cnt_nx  = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nx = '0;
                        if (onehot || PRIORITY != 0) begin
                            addr_nx  = cand_addr;
                            valid_nx = 1'b1;
                            state_nx = HELD;
                        end else begin
                            err_nx   = 1'b1;
                            state_nx = LOCK;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                HELD, LOCK: begin
                    // Any nonzero sample restarts release debouncing; pattern changes are ignored.
                    if (sync2 != '0) begin
                        cnt_nx = '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        rel_nx   = (state == HELD);
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            addr_out    <= '0;
            addr_valid  <= 1'b0;
            err         <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= addr_in;
            sync2       <= sync1;
            cand        <= cand_nx;
            cnt         <= cnt_nx;
            state       <= state_nx;
            addr_out    <= addr_nx;
            addr_valid  <= valid_nx;
            err         <= err_nx;
            key_release <= rel_nx;
        end
    end

    assign key_held = (state == HELD);
endmodule
